// File: rtl/sholva_pkg.sv
// sholva_pkg: shared encodings for the register-file writeback path.
//   - GPR select codes (3 bit) and full write-select codes (4 bit, adds eip/eflags)
//   - partial-write width codes
//   - EFLAGS reserved bit that always reads as one
//   - writeback FSM states, the held commit packet, and the stage-skip helper
package sholva_pkg;

    localparam logic [2:0] GPR_EAX = 3'd0;
    localparam logic [2:0] GPR_ECX = 3'd1;
    localparam logic [2:0] GPR_EDX = 3'd2;
    localparam logic [2:0] GPR_EBX = 3'd3;
    localparam logic [2:0] GPR_ESP = 3'd4;
    localparam logic [2:0] GPR_EBP = 3'd5;
    localparam logic [2:0] GPR_ESI = 3'd6;
    localparam logic [2:0] GPR_EDI = 3'd7;

    localparam logic [3:0] SEL_EIP    = 4'd8;
    localparam logic [3:0] SEL_EFLAGS = 4'd9;

    localparam logic [1:0] WID_8L = 2'd0;
    localparam logic [1:0] WID_8H = 2'd1;
    localparam logic [1:0] WID_16 = 2'd2;
    localparam logic [1:0] WID_32 = 2'd3;

    localparam logic [31:0] EFLAGS_RSVD = 32'h0000_0002;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR0   = 3'd1,
        ST_WR1   = 3'd2,
        ST_FLAGS = 3'd3,
        ST_EIP   = 3'd4
    } state_t;

    typedef struct packed {
        logic        en0;
        logic [2:0]  sel0;
        logic [1:0]  wid0;
        logic [31:0] val0;
        logic        en1;
        logic [2:0]  sel1;
        logic [1:0]  wid1;
        logic [31:0] val1;
        logic        flags_en;
        logic [31:0] flags_mask;
        logic [31:0] flags_val;
        logic [31:0] next_eip;
    } pkt_t;

    // Next stage after s, skipping disabled writes. EIP is never skipped and
    // always returns to IDLE.
    function automatic state_t next_stage(state_t s, logic en0, logic en1, logic fe);
        state_t n;
        n = ST_IDLE;
        case (s)
            ST_IDLE:  n = en0 ? ST_WR0 : (en1 ? ST_WR1 : (fe ? ST_FLAGS : ST_EIP));
            ST_WR0:   n = en1 ? ST_WR1 : (fe ? ST_FLAGS : ST_EIP);
            ST_WR1:   n = fe ? ST_FLAGS : ST_EIP;
            ST_FLAGS: n = ST_EIP;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/reg_merge.sv
// reg_merge: combinational partial-register merge.
//   cur    [31:0] current register contents
//   val    [31:0] right-aligned write data
//   wid    [1:0]  width code (8L, 8H, 16, 32)
//   merged [31:0] value to write back
module reg_merge
    import sholva_pkg::*;
(
    input  logic [31:0] cur,
    input  logic [31:0] val,
    input  logic [1:0]  wid,
    output logic [31:0] merged
);

    always_comb begin
        merged = val;
        case (wid)
            WID_8L:  merged = {cur[31:8], val[7:0]};
            WID_8H:  merged = {cur[31:16], val[7:0], cur[7:0]};
            WID_16:  merged = {cur[31:16], val[15:0]};
            WID_32:  merged = val;
            default: merged = val;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: sequences one commit packet into register-file writes.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       commit handshake
//   i_dst0_* / i_dst1_*     two GPR writes (enable, select, width, data)
//   i_flags_*               masked EFLAGS update
//   i_next_eip              EIP value written last
//   i_eax .. i_eflags       current architectural register values
//   o_wr_en/o_wr_sel/o_wr_val  one register write per cycle (sel 0-7 GPR, 8 eip, 9 eflags)
//   o_done                  pulses in the EIP write cycle
//   o_err                   sticky illegal-write flag
//   o_state                 current FSM state, for observation
//
// Handshake: a packet transfers on a rising edge where i_valid=1 and
// o_ready=1. o_ready is high only in IDLE; i_valid is ignored elsewhere and
// the producer must hold the packet until the transfer edge.
module regfile_writeback
    import sholva_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_dst0_en,
    input  logic [2:0]  i_dst0_sel,
    input  logic [1:0]  i_dst0_wid,
    input  logic [31:0] i_dst0_val,
    input  logic        i_dst1_en,
    input  logic [2:0]  i_dst1_sel,
    input  logic [1:0]  i_dst1_wid,
    input  logic [31:0] i_dst1_val,
    input  logic        i_flags_en,
    input  logic [31:0] i_flags_mask,
    input  logic [31:0] i_flags_val,
    input  logic [31:0] i_next_eip,
    input  logic [31:0] i_eax,
    input  logic [31:0] i_ebx,
    input  logic [31:0] i_ecx,
    input  logic [31:0] i_edx,
    input  logic [31:0] i_esi,
    input  logic [31:0] i_edi,
    input  logic [31:0] i_esp,
    input  logic [31:0] i_ebp,
    input  logic [31:0] i_eip,
    input  logic [31:0] i_eflags,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_sel,
    output logic [31:0] o_wr_val,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_state
);

    state_t      state;
    pkt_t        pkt;
    logic        err_q;

    logic [2:0]  issue_sel;
    logic [1:0]  issue_wid;
    logic [31:0] issue_val;
    logic [31:0] cur;
    logic [31:0] merged;
    logic        is_gpr;
    logic        illegal_now;

    // i_eip is not needed: the EIP write always takes the packet's next_eip.
    logic        unused_eip;
    assign unused_eip = ^i_eip;

    assign o_ready = (state == ST_IDLE);
    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            pkt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (illegal_now) begin
                err_q <= 1'b1;
            end
            if (state == ST_IDLE) begin
                if (i_valid) begin
                    pkt <= '{en0: i_dst0_en, sel0: i_dst0_sel, wid0: i_dst0_wid, val0: i_dst0_val,
                             en1: i_dst1_en, sel1: i_dst1_sel, wid1: i_dst1_wid, val1: i_dst1_val,
                             flags_en: i_flags_en, flags_mask: i_flags_mask,
                             flags_val: i_flags_val, next_eip: i_next_eip};
                    state <= next_stage(ST_IDLE, i_dst0_en, i_dst1_en, i_flags_en);
                end
            end else begin
                state <= next_stage(state, pkt.en0, pkt.en1, pkt.flags_en);
            end
        end
    end

    // Pick the GPR write for the current stage.
    always_comb begin
        issue_sel = pkt.sel0;
        issue_wid = pkt.wid0;
        issue_val = pkt.val0;
        if (state == ST_WR1) begin
            issue_sel = pkt.sel1;
            issue_wid = pkt.wid1;
            issue_val = pkt.val1;
        end
    end

    // Merge base is the live register input, so a WR1 to the same register
    // sees WR0's result once the register file has absorbed it.
    always_comb begin
        cur = i_eax;
        case (issue_sel)
            GPR_EAX: cur = i_eax;
            GPR_ECX: cur = i_ecx;
            GPR_EDX: cur = i_edx;
            GPR_EBX: cur = i_ebx;
            GPR_ESP: cur = i_esp;
            GPR_EBP: cur = i_ebp;
            GPR_ESI: cur = i_esi;
            GPR_EDI: cur = i_edi;
            default: cur = i_eax;
        endcase
    end

    reg_merge u_merge (
        .cur    (cur),
        .val    (issue_val),
        .wid    (issue_wid),
        .merged (merged)
    );

    // AH/CH/DH/BH exist only for selects 0-3; 8H on esp..edi has no encoding.
    assign is_gpr      = (state == ST_WR0) || (state == ST_WR1);
    assign illegal_now = is_gpr && (issue_wid == WID_8H) && (issue_sel >= GPR_ESP);

    always_comb begin
        o_wr_en  = 1'b0;
        o_wr_sel = 4'd0;
        o_wr_val = 32'd0;
        o_done   = 1'b0;
        if (!i_rst) begin
            case (state)
                ST_WR0, ST_WR1: begin
                    if (!illegal_now) begin
                        o_wr_en  = 1'b1;
                        o_wr_sel = {1'b0, issue_sel};
                        o_wr_val = merged;
                    end
                end
                ST_FLAGS: begin
                    o_wr_en  = 1'b1;
                    o_wr_sel = SEL_EFLAGS;
                    o_wr_val = (i_eflags & ~pkt.flags_mask) | (pkt.flags_val & pkt.flags_mask)
                               | EFLAGS_RSVD;
                end
                ST_EIP: begin
                    o_wr_en  = 1'b1;
                    o_wr_sel = SEL_EIP;
                    o_wr_val = pkt.next_eip;
                    o_done   = 1'b1;
                end
                default: begin
                    o_wr_en = 1'b0;
                end
            endcase
        end
    end

    // Error is visible in the offending cycle and held afterwards.
    assign o_err = (err_q | illegal_now) & ~i_rst;

endmodule
